// File: rtl/param_task_scheduler.sv
// Parametrised task scheduler: walks a synchronous-read task memory, applies fences,
// streams instruction frames to masked cores and pulses Start, with frame-sync handshake.
module param_task_scheduler #(
   parameter int unsigned NUM_CORES  = 4,
   parameter int unsigned TM_DEPTH   = 256,
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned TM_W       = 64,
   parameter int unsigned LOAD_BEATS = 4,
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned BEAT_W     = (LOAD_BEATS > 1) ? $clog2(LOAD_BEATS) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run,
   output logic [ADDR_W-1:0]    tm_addr,
   input  logic [TM_W-1:0]      tm_rdata,
   input  logic [NUM_CORES-1:0] Ready,
   output logic [NUM_CORES-1:0] Start,
   output logic                 Insn_Valid,
   output logic [BEAT_W-1:0]    Insn_Beat,
   output logic [TM_W-1:0]      Insn_Data,
   output logic [NUM_CORES-1:0] Insn_Load_Vect,
   output logic                 frame_done,
   input  logic                 frame_go,
   output logic                 busy,
   output logic [ADDR_W-1:0]    cur_ptr
);

   localparam int unsigned CNT_LSB   = 0;
   localparam int unsigned MASK_LSB  = CNT_W;
   localparam int unsigned FENCE_LSB = CNT_W + NUM_CORES;
   localparam int unsigned STOP_BIT  = FENCE_LSB + 2;
   localparam int unsigned JUMP_LSB  = STOP_BIT + 1;
   localparam int unsigned HDR_W     = JUMP_LSB + ADDR_W;
   localparam int unsigned LD_W      = $clog2(LOAD_BEATS + 1);
   localparam logic [LD_W-1:0]   LD_LAST = LD_W'(LOAD_BEATS);
   localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(TM_DEPTH);

   if (HDR_W > TM_W) begin : g_hdr_too_wide
      $error("task header fields do not fit in a TM_W-bit word");
   end

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_WAIT_ALL, S_WAIT_MASK,
      S_LOAD, S_START, S_GUARD, S_POST, S_SYNC
   } state_e;

   typedef enum logic [1:0] {F_NO = 2'd0, F_ACQ = 2'd1, F_REL = 2'd2, F_NO3 = 2'd3} fence_e;

   state_e                state_q, state_d;
   logic [ADDR_W-1:0]     ptr_q;
   logic [NUM_CORES-1:0]  mask_q;
   fence_e                fence_q;
   logic                  stop_q;
   logic [ADDR_W-1:0]     jump_q;
   logic [CNT_W-1:0]      frames_q;
   logic [LD_W-1:0]       ld_cnt_q;
   logic                  sync_first_q;

   fence_e                hdr_fence;
   logic [CNT_W-1:0]      hdr_cnt;

   assign hdr_fence = fence_e'(tm_rdata[FENCE_LSB +: 2]);
   assign hdr_cnt   = tm_rdata[CNT_LSB +: CNT_W];
   assign busy      = (state_q != S_IDLE);
   assign cur_ptr   = ptr_q;

   // Modular add so the pointer wraps at TM_DEPTH even when it is not a power of two.
   function automatic logic [ADDR_W-1:0] addr_add(input logic [ADDR_W-1:0] a,
                                                  input logic [ADDR_W-1:0] k);
      logic [ADDR_W:0] s;
      s = {1'b0, a} + {1'b0, k};
      if (s >= DEPTH_X) s = s - DEPTH_X;
      return s[ADDR_W-1:0];
   endfunction

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         ptr_q        <= '0;
         mask_q       <= '0;
         fence_q      <= F_NO;
         stop_q       <= 1'b0;
         jump_q       <= '0;
         frames_q     <= '0;
         ld_cnt_q     <= '0;
         sync_first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_DECODE: begin
               frames_q <= hdr_cnt;
               mask_q   <= tm_rdata[MASK_LSB +: NUM_CORES];
               fence_q  <= hdr_fence;
               stop_q   <= tm_rdata[STOP_BIT];
               jump_q   <= tm_rdata[JUMP_LSB +: ADDR_W];
               ptr_q    <= addr_add(ptr_q, ADDR_W'(1));
            end
            S_LOAD: begin
               if (ld_cnt_q == LD_LAST) begin
                  ld_cnt_q <= '0;
                  ptr_q    <= addr_add(ptr_q, ADDR_W'(LOAD_BEATS));
               end else begin
                  ld_cnt_q <= ld_cnt_q + 1'b1;
               end
            end
            S_START: frames_q <= frames_q - 1'b1;
            S_POST:  sync_first_q <= 1'b1;
            S_SYNC: begin
               sync_first_q <= 1'b0;
               if (frame_go) ptr_q <= jump_q;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d        = state_q;
      tm_addr        = ptr_q;
      Start          = '0;
      Insn_Valid     = 1'b0;
      Insn_Beat      = '0;
      Insn_Data      = '0;
      Insn_Load_Vect = '0;
      frame_done     = 1'b0;
      case (state_q)
         S_IDLE:   if (run) state_d = S_FETCH;
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            if (hdr_fence == F_ACQ)   state_d = S_WAIT_ALL;
            else if (hdr_cnt == '0)   state_d = S_POST;
            else                      state_d = S_WAIT_MASK;
         end
         S_WAIT_ALL: if (&Ready) state_d = (frames_q == '0) ? S_POST : S_WAIT_MASK;
         S_WAIT_MASK: if ((mask_q & ~Ready) == '0) state_d = S_LOAD;
         // Address for beat k goes out in cycle k; its data returns and is presented in cycle k+1.
         S_LOAD: begin
            if (ld_cnt_q != LD_LAST) tm_addr = addr_add(ptr_q, ADDR_W'(ld_cnt_q));
            if (ld_cnt_q != '0) begin
               Insn_Valid     = 1'b1;
               Insn_Beat      = BEAT_W'(ld_cnt_q - 1'b1);
               Insn_Data      = tm_rdata;
               Insn_Load_Vect = mask_q;
            end
            if (ld_cnt_q == LD_LAST) state_d = S_START;
         end
         S_START: begin
            Start   = mask_q;
            state_d = S_GUARD;
         end
         S_GUARD: state_d = (frames_q != '0) ? S_WAIT_MASK : S_POST;
         S_POST: begin
            if (!((fence_q == F_REL) || stop_q) || (&Ready))
               state_d = stop_q ? S_SYNC : (run ? S_FETCH : S_IDLE);
         end
         S_SYNC: begin
            frame_done = sync_first_q;
            if (frame_go) state_d = run ? S_FETCH : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule
